// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan controller: register map, CTRL layout,
// reset constants and the hex-to-segment table (segments {g,f,e,d,c,b,a}, active-low).
package sevseg_pkg;

  typedef logic [1:0] addr_t;

  localparam addr_t ADDR_VALUE  = 2'd0;
  localparam addr_t ADDR_CTRL   = 2'd1;
  localparam addr_t ADDR_DIM    = 2'd2;
  localparam addr_t ADDR_STATUS = 2'd3;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [3:0] mask;
    logic [2:0] rsvd_lo;
    logic       en;
  } ctrl_t;

  localparam logic [15:0] CTRL_RST   = 16'h00F1;
  localparam logic [15:0] CTRL_WMASK = 16'h00F1;
  localparam logic [15:0] DIM_RST    = 16'h000F;
  localparam logic [15:0] VALUE_RST  = 16'h0000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] SEL_NONE  = 4'hF;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevseg_if.sv
// Register bus between a host and the scan controller: req held until a one-cycle ack,
// read data valid only alongside ack.
interface sevseg_bus_if;
  import sevseg_pkg::*;

  logic        bus_req;
  logic        bus_we;
  addr_t       bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/sevseg_decoder.sv
// Combinational hex nibble to active-low segment pattern; zero latency, no flow control.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_decode(nibble);
  end

endmodule

// File: rtl/sevseg_ctrl.sv
// Four-digit multiplexed seven-segment driver with a register bus; pins lag slot state by one cycle.
// Bus ack one cycle after an accepted req, never back-to-back; SEVSEG_DIM_EN adds a DIM brightness level.
module sevseg_ctrl
  import sevseg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int DEAD_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  sevseg_bus_if.slave        bus,
  output logic [6:0]         seg,
  output logic [3:0]         sel
);

  localparam int            CW       = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [15:0]   active_q, active_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          ack_q, ack_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;
`ifdef SEVSEG_DIM_EN
  logic [3:0]    dim_q, dim_d;
`endif

  logic          accept;
  logic          wr_en;
  logic          rd_en;
  logic          slot_wrap;
  logic          frame_wrap;
  logic          in_dead;
  logic          bright;
  logic          lit;
  logic [15:0]   rd_val;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  sevseg_decoder u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Bus side: a request is only taken while no ack is outstanding.
  always_comb begin
    accept     = bus.bus_req && !ack_q;
    wr_en      = accept && bus.bus_we;
    rd_en      = accept && !bus.bus_we;
    slot_wrap  = (slot_cnt_q == LAST_CNT);
    frame_wrap = slot_wrap && (digit_q == 2'd3);
    in_dead    = (slot_cnt_q < DEAD_CNT);

    slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;

    shadow_d = shadow_q;
    active_d = frame_wrap ? shadow_q : active_q;
    ctrl_d   = ctrl_q;
`ifdef SEVSEG_DIM_EN
    dim_d    = dim_q;
`endif

    if (wr_en) begin
      case (bus.bus_addr)
        ADDR_VALUE: begin
          shadow_d = bus.bus_wdata;
          // A write landing on the frame boundary must not be lost for a whole frame.
          if (frame_wrap) active_d = bus.bus_wdata;
        end
        ADDR_CTRL: ctrl_d = ctrl_t'(bus.bus_wdata & CTRL_WMASK);
        ADDR_DIM: begin
`ifdef SEVSEG_DIM_EN
          dim_d = bus.bus_wdata[3:0];
`endif
        end
        default: ;
      endcase
    end

    rd_val = '0;
    case (bus.bus_addr)
      ADDR_VALUE:  rd_val = shadow_q;
      ADDR_CTRL:   rd_val = ctrl_q;
      ADDR_DIM: begin
`ifdef SEVSEG_DIM_EN
        rd_val = {12'd0, dim_q};
`endif
      end
      ADDR_STATUS: rd_val = {13'd0, in_dead, digit_q};
      default:     rd_val = '0;
    endcase

    ack_d   = accept;
    rdata_d = rd_en ? rd_val : '0;
  end

  // Display side: decide what the pins show for the current slot.
  always_comb begin
`ifdef SEVSEG_DIM_EN
    bright = (slot_cnt_q[3:0] <= dim_q);
`else
    bright = 1'b1;
`endif
    lit    = !in_dead && ctrl_q.en && ctrl_q.mask[digit_q] && bright;
    nibble = active_q[{digit_q, 2'b00} +: 4];
    sel_d  = lit ? ~(4'b0001 << digit_q) : SEL_NONE;
    seg_d  = lit ? dec_seg : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      digit_q    <= '0;
      shadow_q   <= VALUE_RST;
      active_q   <= VALUE_RST;
      ctrl_q     <= ctrl_t'(CTRL_RST);
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      seg_q      <= SEG_BLANK;
      sel_q      <= SEL_NONE;
`ifdef SEVSEG_DIM_EN
      dim_q      <= DIM_RST[3:0];
`endif
    end else begin
      slot_cnt_q <= slot_cnt_d;
      digit_q    <= digit_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      ctrl_q     <= ctrl_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
`ifdef SEVSEG_DIM_EN
      dim_q      <= dim_d;
`endif
    end
  end

  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;
  assign seg           = seg_q;
  assign sel           = sel_q;

endmodule

// File: tb/tb_sevseg_ctrl.sv
// Bench for sevseg_ctrl (DIGIT_CYCLES=32, DEAD_CYCLES=4): behavioural model feeds a scoreboard
// of expected pins and read data, plus directed scan, masking, dimming and reset scenarios.
module tb_sevseg_ctrl;

  localparam int DC = 32;
  localparam int DD = 4;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } pins_t;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] sel;

  sevseg_bus_if bus ();

  sevseg_ctrl #(
    .DIGIT_CYCLES (DC),
    .DEAD_CYCLES  (DD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .seg (seg),
    .sel (sel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model of the register/scan behaviour.
  int          m_cnt;
  int          m_dig;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_en;
  logic [3:0]  m_mask;
  logic [3:0]  m_dim;
  logic        m_ack;
  pins_t       disp_q [$];
  logic [15:0] rd_q [$];

  always @(posedge clk) begin : model
    logic        acc;
    logic        frame;
    logic        lit;
    logic [3:0]  nib;
    logic [15:0] rv;
    pins_t       p;
    if (rst) begin
      m_cnt    <= 0;
      m_dig    <= 0;
      m_shadow <= 16'h0;
      m_active <= 16'h0;
      m_en     <= 1'b1;
      m_mask   <= 4'hF;
      m_dim    <= 4'hF;
      m_ack    <= 1'b0;
      p.sel = 4'hF;
      p.seg = 7'h7F;
      disp_q.push_back(p);
      rd_q.delete();
    end else begin
      lit = (m_cnt >= DD) && m_en && m_mask[m_dig];
`ifdef SEVSEG_DIM_EN
      lit = lit && ((m_cnt % 16) <= int'(m_dim));
`endif
      nib   = 4'((m_active >> (4 * m_dig)) & 16'hF);
      p.sel = lit ? ~(4'b0001 << m_dig) : 4'hF;
      p.seg = lit ? SEG_TBL[nib] : 7'h7F;
      disp_q.push_back(p);

      case (bus.bus_addr)
        2'd0: rv = m_shadow;
        2'd1: rv = {8'h00, m_mask, 3'b000, m_en};
`ifdef SEVSEG_DIM_EN
        2'd2: rv = {12'h000, m_dim};
`else
        2'd2: rv = 16'h0000;
`endif
        default: rv = {13'd0, (m_cnt < DD), 2'(m_dig)};
      endcase

      acc   = bus.bus_req && !m_ack;
      frame = (m_cnt == DC - 1) && (m_dig == 3);
      m_ack <= acc;
      if (acc) rd_q.push_back(bus.bus_we ? 16'h0000 : rv);
      if (frame) m_active <= m_shadow;
      if (acc && bus.bus_we) begin
        if (bus.bus_addr == 2'd0) begin
          m_shadow <= bus.bus_wdata;
          if (frame) m_active <= bus.bus_wdata;
        end else if (bus.bus_addr == 2'd1) begin
          m_en   <= bus.bus_wdata[0];
          m_mask <= bus.bus_wdata[7:4];
`ifdef SEVSEG_DIM_EN
        end else if (bus.bus_addr == 2'd2) begin
          m_dim <= bus.bus_wdata[3:0];
`endif
        end
      end
      m_cnt <= (m_cnt == DC - 1) ? 0 : m_cnt + 1;
      m_dig <= (m_cnt == DC - 1) ? (m_dig + 1) % 4 : m_dig;
    end
  end

  always @(negedge clk) begin : monitor
    pins_t       e;
    logic [15:0] er;
    if (disp_q.size() > 0) begin
      e = disp_q.pop_front();
      check("sel", 32'(sel), 32'(e.sel));
      check("seg", 32'(seg), 32'(e.seg));
      check("ack", 32'(bus.bus_ack), 32'(m_ack));
      if (bus.bus_ack === 1'b1) begin
        if (rd_q.size() > 0) begin
          er = rd_q.pop_front();
          check("rdata", 32'(bus.bus_rdata), 32'(er));
        end else begin
          check("ack_unexpected", 32'(bus.bus_ack), 32'd0);
        end
      end else begin
        check("rdata_idle", 32'(bus.bus_rdata), 32'd0);
      end
    end
  end

  task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [15:0] d,
                          output logic [15:0] rd);
    int n;
    bus.bus_req   = 1'b1;
    bus.bus_we    = w;
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.bus_ack !== 1'b1 && n < 20);
    check("xfer_ack", 32'(bus.bus_ack), 32'd1);
    rd = bus.bus_rdata;
    bus.bus_req = 1'b0;
    bus.bus_we  = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] unused_rd;
    bus_xfer(1'b1, a, d, unused_rd);
  endtask

  task automatic bus_rd_chk(input logic [1:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] rd;
    bus_xfer(1'b0, a, 16'h0000, rd);
    check(tag, 32'(rd), 32'(exp));
  endtask

  task automatic wait_sel(input logic [3:0] pat, input logic [6:0] exp_seg, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel !== pat && n < 200);
    check({tag, "_sel"}, 32'(sel), 32'(pat));
    check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
  endtask

  task automatic count_win(input int ncyc, output int n_lit, output int n_e,
                           output int n_b, output int n_odd);
    n_lit = 0;
    n_e   = 0;
    n_b   = 0;
    n_odd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (sel !== 4'hF) n_lit++;
      if (sel === 4'hE) n_e++;
      if (sel === 4'hB) n_b++;
      if (sel === 4'hD || sel === 4'h7) n_odd++;
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n_lit, n_e, n_b, n_odd, n_ack, n_dbl, n;
    logic prev;
    rst           = 1'b1;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 2'd0;
    bus.bus_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // One frame after reset: digits scanned in order, all showing 0.
    wait_sel(4'hE, 7'b1000000, "frame_d0");
    wait_sel(4'hD, 7'b1000000, "frame_d1");
    wait_sel(4'hB, 7'b1000000, "frame_d2");
    wait_sel(4'h7, 7'b1000000, "frame_d3");
    count_win(4 * DC, n_lit, n_e, n_b, n_odd);
    check("dead_cycles_per_frame", 32'(4 * DC - n_lit), 32'(4 * DD));

    bus_rd_chk(2'd1, 16'h00F1, "ctrl_rst");
`ifdef SEVSEG_DIM_EN
    bus_rd_chk(2'd2, 16'h000F, "dim_rst");
`else
    bus_rd_chk(2'd2, 16'h0000, "dim_rst");
`endif
    bus_rd_chk(2'd0, 16'h0000, "value_rst");

    // VALUE goes to shadow now, to the display only at the next frame wrap.
    wait_sel(4'hD, 7'b1000000, "pre_d1");
    bus_wr(2'd0, 16'h1A20);
    bus_rd_chk(2'd0, 16'h1A20, "value_readback");
    wait_sel(4'hB, 7'b1000000, "hold_d2");
    wait_sel(4'hE, 7'b1000000, "new_d0");
    wait_sel(4'hD, 7'b0100100, "new_d1");
    wait_sel(4'hB, 7'b0001000, "new_d2");
    wait_sel(4'h7, 7'b1111001, "new_d3");

    // Digit mask and reserved CTRL bits.
    bus_wr(2'd1, 16'hFF51);
    bus_rd_chk(2'd1, 16'h0051, "ctrl_reserved");
    repeat (2) @(negedge clk);
    count_win(4 * DC, n_lit, n_e, n_b, n_odd);
    check("mask_d0_lit", 32'(n_e), 32'(DC - DD));
    check("mask_d2_lit", 32'(n_b), 32'(DC - DD));
    check("mask_d13_dark", 32'(n_odd), 32'd0);
    bus_wr(2'd1, 16'h0000);
    repeat (2) @(negedge clk);
    count_win(4 * DC, n_lit, n_e, n_b, n_odd);
    check("disable_dark", 32'(n_lit), 32'd0);
    bus_wr(2'd1, 16'h00F1);

    // Brightness level.
    bus_wr(2'd2, 16'h0003);
    repeat (2) @(negedge clk);
    count_win(4 * DC, n_lit, n_e, n_b, n_odd);
`ifdef SEVSEG_DIM_EN
    check("dim_lit", 32'(n_lit), 32'd16);
    bus_rd_chk(2'd2, 16'h0003, "dim_readback");
    bus_wr(2'd2, 16'h000F);
`else
    check("dim_lit", 32'(n_lit), 32'(4 * (DC - DD)));
    bus_rd_chk(2'd2, 16'h0000, "dim_readback");
`endif

    // STATUS is read-only; repeated reads with req held.
    bus_wr(2'd3, 16'hFFFF);
    @(negedge clk);
    bus.bus_req  = 1'b1;
    bus.bus_we   = 1'b0;
    bus.bus_addr = 2'd3;
    n_ack = 0;
    n_dbl = 0;
    prev  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (bus.bus_ack === 1'b1) begin
        n_ack++;
        if (prev) n_dbl++;
      end
      prev = (bus.bus_ack === 1'b1);
    end
    n = 0;
    while (bus.bus_ack !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.bus_req = 1'b0;
    check("b2b_acks", 32'(n_ack), 32'd8);
    check("b2b_double", 32'(n_dbl), 32'd0);

    // VALUE write accepted exactly in the frame-wrap cycle goes straight to the display.
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(m_cnt == DC - 1 && m_dig == 3) && n < 300);
    bus_wr(2'd0, 16'h5B3C);
    wait_sel(4'hE, 7'b1000110, "edge_d0");
    wait_sel(4'hD, 7'b0110000, "edge_d1");
    bus_rd_chk(2'd0, 16'h5B3C, "edge_readback");

    // Reset during a pending write aborts it.
    wait_sel(4'hB, 7'b0000011, "pre_rst_d2");
    bus.bus_req   = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = 2'd1;
    bus.bus_wdata = 16'h0000;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.bus_req = 1'b0;
    bus.bus_we  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_ack", 32'(bus.bus_ack), 32'd0);
    end
    bus_rd_chk(2'd0, 16'h0000, "rst_value");
    bus_rd_chk(2'd1, 16'h00F1, "rst_ctrl");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel === 4'hF && n < 200);
    check("rst_first_digit", 32'(sel), 32'hE);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
